// File: rtl/folded_fir_pkg.sv
// Shared types and constants for the folded polyphase FIR family.
// Pure declarations: no latency, no flow control.
package folded_fir_pkg;
  localparam int DW_DEF    = 12;
  localparam int CW_DEF    = 13;
  localparam int OW_DEF    = 22;
  localparam int TAPS_DEF  = 5;
  localparam int RND_SHIFT = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN1, DRAIN2} state_t;
endpackage

// File: rtl/fir_mac_round.sv
// Single-multiplier MAC: product, round-half-up shift, accumulate (clamped under FOLDED_INTERP_SAT_EN).
// Latency: accumulator updates one edge after each valid operand pair; no backpressure.
module fir_mac_round
  import folded_fir_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 op_vld,
  input  logic                 op_first,
  input  logic signed [DW-1:0] x_op,
  input  logic signed [CW-1:0] h_op,
  output logic signed [OW-1:0] acc
);
  localparam int PW = DW + CW;

  logic signed [PW-1:0] prod;
  logic signed [OW-1:0] shifted;
  logic signed [OW-1:0] rnd_bit;
  logic signed [OW-1:0] term;
  logic signed [OW-1:0] base;
  logic signed [OW-1:0] sum_nxt;

  assign prod    = x_op * h_op;
  assign shifted = OW'(prod >>> RND_SHIFT);
  assign rnd_bit = OW'(prod[RND_SHIFT-1]);
  assign term    = shifted + rnd_bit;
  // First tap of a phase starts a fresh sum rather than clearing acc separately.
  assign base    = op_first ? '0 : acc;

`ifdef FOLDED_INTERP_SAT_EN
  localparam logic signed [OW:0] ACC_MAX = {2'b00, {(OW-1){1'b1}}};
  localparam logic signed [OW:0] ACC_MIN = {2'b11, {(OW-1){1'b0}}};
  logic signed [OW:0] sum_wide;

  assign sum_wide = {base[OW-1], base} + {term[OW-1], term};

  always_comb begin
    if (sum_wide > ACC_MAX)
      sum_nxt = ACC_MAX[OW-1:0];
    else if (sum_wide < ACC_MIN)
      sum_nxt = ACC_MIN[OW-1:0];
    else
      sum_nxt = sum_wide[OW-1:0];
  end
`else
  assign sum_nxt = base + term;
`endif

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset)
      acc <= '0;
    else if (op_vld)
      acc <= sum_nxt;
  end
endmodule

// File: rtl/folded_interp_filter.sv
// 2x polyphase interpolator, 10-tap prototype folded onto one MAC; FOLDED_INTERP_SAT_EN enables clamping.
// Latency 7 / 12 cycles to phase-0 / phase-1 output; a_ready low 11 cycles per accepted sample.
module folded_interp_filter
  import folded_fir_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int OW   = OW_DEF,
  parameter int TAPS = TAPS_DEF
) (
  input  logic                   clk100,
  input  logic                   reset,
  input  logic signed [DW-1:0]   a,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [CW*2*TAPS-1:0]   c,
  output logic signed [OW-1:0]   b,
  output logic                   b_valid
);
  localparam int KW = $clog2(TAPS);

  state_t               state, state_nxt;
  logic                 rstn_q;
  logic [KW-1:0]        k;
  logic                 phase;
  logic signed [DW-1:0] x [TAPS];
  logic signed [DW-1:0] x_op;
  logic signed [CW-1:0] h_op;
  logic signed [CW-1:0] h_sel;
  logic                 op_vld, op_first, op_last, done_q;
  logic                 take, k_last;
  logic signed [OW-1:0] acc;

  assign a_ready = rstn_q && (state == IDLE || state == DRAIN2);
  assign take    = a_valid && a_ready;
  assign k_last  = (k == KW'(TAPS - 1));
  // Interleaved prototype: phase p tap k is h[2k+p].
  assign h_sel   = c[int'({k, phase})*CW +: CW];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = RUN;
      RUN:     if (phase && k_last) state_nxt = DRAIN1;
      DRAIN1:  state_nxt = DRAIN2;
      DRAIN2:  state_nxt = take ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rstn_q   <= 1'b0;
      k        <= '0;
      phase    <= 1'b0;
      x_op     <= '0;
      h_op     <= '0;
      op_vld   <= 1'b0;
      op_first <= 1'b0;
      op_last  <= 1'b0;
      done_q   <= 1'b0;
      b        <= '0;
      b_valid  <= 1'b0;
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
    end else begin
      state  <= state_nxt;
      rstn_q <= 1'b1;

      if (take) begin
        k     <= '0;
        phase <= 1'b0;
        x[0]  <= a;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
      end else if (state == RUN) begin
        if (k_last) begin
          k     <= '0;
          phase <= ~phase;
        end else begin
          k <= k + 1'b1;
        end
      end

      op_vld <= (state == RUN);
      if (state == RUN) begin
        x_op     <= x[k];
        h_op     <= h_sel;
        op_first <= (k == '0);
        op_last  <= k_last;
      end

      // done_q marks the edge the last tap landed in acc; capture it one edge later.
      done_q  <= op_vld && op_last;
      b_valid <= done_q;
      if (done_q) b <= acc;
    end
  end

  fir_mac_round #(.DW(DW), .CW(CW), .OW(OW)) u_mac (
    .clk100   (clk100),
    .reset    (reset),
    .op_vld   (op_vld),
    .op_first (op_first),
    .x_op     (x_op),
    .h_op     (h_op),
    .acc      (acc)
  );
endmodule

// File: tb/tb_folded_interp_filter.sv
// Directed + randomized bench for folded_interp_filter against an arithmetic polyphase model.
module tb_folded_interp_filter;
  localparam int DW = 12, CW = 13, OW = 22, TAPS = 5;
`ifdef FOLDED_INTERP_SAT_EN
  localparam int SAT_LIT = 2097151;
`else
  localparam int SAT_LIT = -1572864;
`endif

  logic                  clk100 = 1'b0;
  logic                  reset;
  logic signed [DW-1:0]  a;
  logic                  a_valid;
  logic                  a_ready;
  logic [CW*2*TAPS-1:0]  c;
  logic signed [OW-1:0]  b;
  logic                  b_valid;

  folded_interp_filter #(.DW(DW), .CW(CW), .OW(OW), .TAPS(TAPS)) dut (
    .clk100 (clk100), .reset (reset), .a (a), .a_valid (a_valid), .a_ready (a_ready),
    .c (c), .b (b), .b_valid (b_valid)
  );

  always #5 clk100 = ~clk100;

  int checks = 0, passed = 0;
  int h[10];
  int hist[TAPS];
  int exp_q[$], got_q[$], hs_q[$], bv_q[$], low_q[$];
  int cyc = 0, lowcnt = 0, b2b = 0;
  bit prev_bv = 0;
  int last_y0, last_y1;

  always @(posedge clk100) cyc++;

  // Monitor samples mid-cycle, after the negedge drive settles.
  always begin
    @(negedge clk100);
    #2;
    if (a_valid && a_ready) hs_q.push_back(cyc + 1);
    if (b_valid) begin
      got_q.push_back(int'(b));
      bv_q.push_back(cyc);
      if (prev_bv) b2b++;
    end
    prev_bv = b_valid;
    if (!a_ready) lowcnt++;
    else begin
      if (lowcnt > 0) low_q.push_back(lowcnt);
      lowcnt = 0;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int round_term(input int p);
    int n = p + 8;
    int q = n / 16;
    if ((n % 16) != 0 && n < 0) q--;
    return q;
  endfunction

  function automatic int fit_acc(input int v);
    logic signed [OW-1:0] t;
`ifdef FOLDED_INTERP_SAT_EN
    if (v > 2097151) return 2097151;
    if (v < -2097152) return -2097152;
    return v;
`else
    t = v[OW-1:0];
    return int'(t);
`endif
  endfunction

  function automatic int model_y(input int ph);
    int s = 0;
    for (int k = 0; k < TAPS; k++) s = fit_acc(s + round_term(h[2*k+ph] * hist[k]));
    return s;
  endfunction

  task automatic load_coefs();
    for (int j = 0; j < 10; j++) c[CW*j +: CW] = CW'(h[j]);
  endtask

  task automatic impulse_coefs();
    for (int j = 0; j < 10; j++) h[j] = 16 * (j + 1);
    load_coefs();
  endtask

  task automatic send(input int val, input bit hold);
    int n = 0;
    @(negedge clk100);
    while (!a_ready && n < 100) begin
      @(negedge clk100);
      n++;
    end
    check("ready_wait", a_ready, 1);
    a = DW'(val);
    a_valid = 1'b1;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = val;
    exp_q.push_back(model_y(0));
    exp_q.push_back(model_y(1));
    @(posedge clk100);
    if (!hold) begin
      #1 a_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    int n = 0;
    int ph = 0;
    while (got_q.size() < exp_q.size() && n < 60) begin
      @(negedge clk100);
      n++;
    end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      int g = got_q.pop_front();
      int e = exp_q.pop_front();
      check($sformatf("%s_y%0d", tag, ph), g, e);
      if (ph == 0) last_y0 = g; else last_y1 = g;
      ph ^= 1;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    reset = 1'b0; a = '0; a_valid = 1'b0; c = '0;
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    for (int j = 0; j < 10; j++) h[j] = 0;

    // Reset state
    repeat (3) @(negedge clk100);
    check("rst_b", b, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_a_ready", a_ready, 0);
    reset = 1'b1;
    @(posedge clk100); @(posedge clk100); #1;
    check("rel_a_ready", a_ready, 1);

    // Impulse: expect (1,2) (3,4) ... (9,10) (0,0)
    impulse_coefs();
    send(1, 0);
    for (int i = 0; i < 5; i++) send(0, 0);
    check_outputs("impulse");

    // Rounding with h0=1
    for (int j = 0; j < 10; j++) h[j] = (j == 0) ? 1 : 0;
    load_coefs();
    send(8, 0);  check_outputs("rnd_p8");
    check("rnd_p8_lit", last_y0, 1);
    send(7, 0);  check_outputs("rnd_p7");
    send(-8, 0); check_outputs("rnd_m8");
    send(-9, 0); check_outputs("rnd_m9");
    check("rnd_m9_lit", last_y0, -1);

    // Saturation / wrap
    for (int j = 0; j < 10; j++) h[j] = -4096;
    load_coefs();
    for (int i = 0; i < 5; i++) begin
      send(-2048, 0);
      check_outputs("sat");
    end
    check("sat_lit", last_y0, SAT_LIT);

    // Back-to-back with a_valid held high
    for (int j = 0; j < 10; j++) h[j] = $urandom_range(8191) - 4096;
    load_coefs();
    @(negedge clk100);
    hs_q.delete(); bv_q.delete(); low_q.delete();
    for (int i = 0; i < 4; i++) send($urandom_range(4095) - 2048, 1);
    @(negedge clk100);
    a_valid = 1'b0;
    check_outputs("held");
    repeat (3) @(negedge clk100);
    check("held_hs_count", hs_q.size(), 4);
    check("held_bv_count", bv_q.size(), 8);
    check("held_low_count", low_q.size(), 4);
    for (int i = 0; i < 4 && i < hs_q.size() && 2*i+1 < bv_q.size(); i++) begin
      check("lat_p0", bv_q[2*i] - hs_q[i], 7);
      check("lat_p1", bv_q[2*i+1] - hs_q[i], 12);
      if (i < 3 && i + 1 < hs_q.size()) check("hs_spacing", hs_q[i+1] - hs_q[i], 12);
    end
    foreach (low_q[i]) check("ready_low_len", low_q[i], 11);

    // Reset mid-RUN
    impulse_coefs();
    send(5, 0);
    repeat (4) @(posedge clk100);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_b", b, 0);
    check("mid_rst_b_valid", b_valid, 0);
    check("mid_rst_a_ready", a_ready, 0);
    exp_q.delete();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    repeat (2) @(negedge clk100);
    check("mid_rst_no_out", got_q.size(), 0);
    reset = 1'b1;
    @(posedge clk100); @(posedge clk100); #1;
    check("mid_rel_a_ready", a_ready, 1);
    send(1, 0);
    check_outputs("post_rst");
    check("post_rst_y0", last_y0, 1);
    check("post_rst_y1", last_y1, 2);
    for (int i = 0; i < 4; i++) send(0, 0);
    check_outputs("post_rst_tail");

    // Idle gaps between samples
    send(1, 0);
    check_outputs("gap");
    for (int i = 0; i < 5; i++) begin
      repeat (20) @(negedge clk100);
      check("gap_no_bvalid", got_q.size(), 0);
      check("gap_b_hold", b, last_y1);
      send(0, 0);
      check_outputs("gap");
    end

    // Random coefficients, samples and gaps
    for (int j = 0; j < 10; j++) h[j] = $urandom_range(8191) - 4096;
    load_coefs();
    for (int i = 0; i < 24; i++) begin
      send($urandom_range(4095) - 2048, ($urandom_range(1) == 1));
      @(negedge clk100);
      a_valid = 1'b0;
      if ($urandom_range(3) == 0) check_outputs("rand");
      repeat ($urandom_range(3)) @(negedge clk100);
    end
    check_outputs("rand_tail");

    check("no_back_to_back", b2b, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/folded_interp_filter.md
# folded_interp_filter

2x polyphase interpolating FIR with the multiply-accumulate folded onto one multiplier. It runs on the single fast clock. The block accepts one 12-bit sample per valid/ready handshake and emits two 22-bit output samples per input, phase 0 then phase 1, using a 10-tap prototype filter split into two 5-tap phases. It sits on the synthesis side of the datapath, at the opposite end from the folded decimating/analysis filters, and drives the up-rate sample stream.

## Interface
- DW, 12: input sample width, signed.
- CW, 13: coefficient width, signed.
- OW, 22: output and accumulator width, signed.
- TAPS, 5: taps per phase. Phase count is fixed at 2.
- clk100  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  DW  input sample.
- a_valid  in  1  input sample valid.
- a_ready  out  1  block can accept `a` this cycle.
- c  in  CW*2*TAPS  prototype coefficients. h[j] = c[CW*j +: CW], j = 0..9. Must be static while not in IDLE.
- b  out  OW  output sample, held between updates.
- b_valid  out  1  one-cycle pulse when `b` updates.

## Operation
- Reset values: b=0, b_valid=0, a_ready=0. Delay line x0..x4 = 0, accumulator = 0, state = IDLE.
- rstn_q is set to 1 one edge after reset deasserts. a_ready = rstn_q && (state==IDLE || state==DRAIN2).
- Handshake: a sample is taken when a_valid && a_ready at an edge (E0). At E0 the delay line shifts: x0<=a, xk<=x(k-1). State goes to RUN with k=0, phase=0.
- RUN, edges E1..E10: operand registers load x[k] and h[2k+phase]. k runs 0..4 for phase 0, then 0..4 for phase 1. At E10 the state goes to DRAIN1.
- DRAIN1 -> DRAIN2 at E11. DRAIN2 -> IDLE at E12, or directly to RUN if a handshake occurs at E12.
- The accumulator updates one edge after each operand load (E2..E11). The first tap of each phase adds to 0 instead of the accumulator.
- Output: b <= accumulator at E7 (phase-0 sum) and at E12 (phase-1 sum). b_valid is high for the cycle after each of these edges. b holds otherwise.
- Phase 0 output: y0 = sum h[2k]*x[k]. Phase 1 output: y1 = sum h[2k+1]*x[k].
- Arithmetic:
  - 25-bit signed product.
  - Rounded term r = (prod >>> 4) + prod[3]: 21-bit, round-half-up, sign-extended to OW.
  - Accumulation is OW-bit two's complement and wraps unless saturation is enabled.
- a_valid low while in IDLE: no state change, delay line unchanged, no b_valid.
- An asynchronous reset at any point aborts the current computation and clears all state. The pending phase output is discarded.

## Timing
- Latency: handshake edge E0 -> phase-0 b_valid after E7 (7 cycles) -> phase-1 b_valid after E12 (12 cycles).
- Throughput: 1 input per 12 cycles, i.e. 2 outputs per 12 cycles, with a_valid held high.
- a_ready is low during RUN and DRAIN1, which is 11 consecutive cycles after each handshake.
- The two b_valid pulses per input are exactly 5 cycles apart and never back-to-back.

## Configuration
- FOLDED_INTERP_SAT_EN defined: each accumulate clamps to [-2^21, 2^21-1]. The clamped value feeds the next tap.
- FOLDED_INTERP_SAT_EN undefined: 22-bit wrap-around, with no clamp logic present.

## Structure
- Shared package folded_fir_pkg holds:
  - state enum (IDLE, RUN, DRAIN1, DRAIN2);
  - DW/CW/OW/TAPS default constants;
  - round-shift constant 4.
- One sub-module, fir_mac_round, holds the product, rounding, zero-select, accumulate and the optional saturation, behind FOLDED_INTERP_SAT_EN.
- Top level holds the FSM, tap counter, delay line, coefficient mux and output register.

## Test plan
- Impulse: h[j]=16*(j+1); send a=1 then five a=0. Required outputs in order: (1,2), (3,4), (5,6), (7,8), (9,10), then (0,0).
- Latency/handshake: a_valid held high. b_valid pulses at E0+7 and E0+12, and the next handshake occurs at E12. a_ready is low for exactly 11 cycles per input.
- Rounding: h0=1, others 0, one input at a time. a=8 -> y0=1; a=7 -> y0=0; a=-8 -> y0=0; a=-9 -> y0=-1. y1=0 in all cases.
- Saturation: all h=-4096, a=-2048 repeated five times. The 5th input's y0 is 2097151 with FOLDED_INTERP_SAT_EN, and -1572864 without it.
- Reset mid-RUN: assert reset at E4. b=0, b_valid=0 and a_ready=0 immediately. a_ready=1 two edges after release. A following impulse test gives clean (1,2).
- Idle gaps: a_valid low for 20 cycles between samples. There is no b_valid and b holds its last value. Impulse results are unchanged by the gaps.
